// File: rtl/hilo_div_ctrl.sv
// HI/LO register unit: owns HI/LO and runs DIV/DIVU on an external unsigned iterative divider, plus MULT/MULTU/MTHI/MTLO.
// Latency: MULT/MULTU/MTHI/MTLO write HI/LO at the accepting edge; DIV/DIVU hold busy for WIDTH+2 cycles.
// Backpressure: busy is high while a divide runs, and op_valid is ignored, so the pipeline must hold the op until busy drops.
module hilo_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_en,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    input  logic             div_complete
);

    localparam logic [2:0] OP_DIV   = 3'd0;
    localparam logic [2:0] OP_DIVU  = 3'd1;
    localparam logic [2:0] OP_MULT  = 3'd2;
    localparam logic [2:0] OP_MULTU = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    // Sign fix-ups applied to the unsigned divider results.
    logic q_neg;
    logic r_neg;

    logic accept;
    logic start_div;

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;

    // Two's-complement magnitude; the most negative value maps to itself,
    // which is already the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ('0 - v) : v;
    endfunction

    assign accept    = (state == IDLE) && op_valid && !flush;
    assign start_div = accept && ((op == OP_DIV) || (op == OP_DIVU));

    // Sign-/zero-extend to 2W first so the low 2W bits of an unsigned
    // multiply give the signed or unsigned product respectively.
    assign prod_s = {{WIDTH{rs_data[WIDTH-1]}}, rs_data} * {{WIDTH{rt_data[WIDTH-1]}}, rt_data};
    assign prod_u = {{WIDTH{1'b0}}, rs_data} * {{WIDTH{1'b0}}, rt_data};

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs; flush beats a same-cycle completion.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        div_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start_div) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                div_en = 1'b1;
                if (flush || div_complete) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // HI/LO, divider operands and sign flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi           <= '0;
            lo           <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                case (op)
                    OP_DIV: begin
                        div_dividend <= mag(rs_data);
                        div_divisor  <= mag(rt_data);
                        q_neg        <= rs_data[WIDTH-1] ^ rt_data[WIDTH-1];
                        r_neg        <= rs_data[WIDTH-1];
                    end
                    OP_DIVU: begin
                        div_dividend <= rs_data;
                        div_divisor  <= rt_data;
                        q_neg        <= 1'b0;
                        r_neg        <= 1'b0;
                    end
                    OP_MULT:  {hi, lo} <= prod_s;
                    OP_MULTU: {hi, lo} <= prod_u;
                    OP_MTHI:  hi <= rs_data;
                    OP_MTLO:  lo <= rs_data;
                    default: ;
                endcase
            end
        end else begin
            if (!flush && div_complete) begin
                lo <= q_neg ? ('0 - div_quotient) : div_quotient;
                hi <= r_neg ? ('0 - div_remainder) : div_remainder;
            end
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl with a behavioural iterative divider alongside.
// Divider model raises div_complete after WIDTH+1 enabled edges.
// Vectors are applied back to back, so each op starts in the first idle cycle.
module tb_hilo_div_ctrl;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          op_valid;
    logic [2:0]    op;
    logic [W-1:0]  rs_data;
    logic [W-1:0]  rt_data;
    logic          busy;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          div_en;
    logic [W-1:0]  div_dividend;
    logic [W-1:0]  div_divisor;
    logic [W-1:0]  div_quotient;
    logic [W-1:0]  div_remainder;
    logic          div_complete;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hilo_div_ctrl #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .op_valid      (op_valid),
        .op            (op),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .busy          (busy),
        .hi            (hi),
        .lo            (lo),
        .div_en        (div_en),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_complete  (div_complete)
    );

    // Divider model: restarts whenever div_en is low; result after W+1 enabled edges.
    logic [7:0] mcnt = 8'd0;
    always_ff @(posedge clk) begin
        if (!div_en) mcnt <= 8'd0;
        else         mcnt <= mcnt + 8'd1;
    end
    assign div_complete  = div_en && (mcnt == 8'(W + 1));
    assign div_quotient  = (div_divisor == '0) ? '1 : div_dividend / div_divisor;
    assign div_remainder = (div_divisor == '0) ? div_dividend : div_dividend % div_divisor;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        logic [W-1:0] exp_dvd;
        logic [W-1:0] exp_dvs;
        int           exp_busy;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Drive an op from a negedge; returns at the negedge after the accepting edge.
    task automatic apply_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op_valid = 1'b1;
        op       = o;
        rs_data  = a;
        rt_data  = b;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    // Count cycles with busy high (bounded), ending at the first idle negedge.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        vecs[0]  = '{3'd1, 32'd100,       32'd7,        32'd2,        32'd14,       32'd100,      32'd7, 34};
        vecs[1]  = '{3'd0, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 32'd7,        32'd2, 34};
        vecs[2]  = '{3'd0, 32'd7,         32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 32'd7,        32'd2, 34};
        vecs[3]  = '{3'd0, 32'h80000000,  32'hFFFFFFFF, 32'd0,        32'h80000000, 32'h80000000, 32'd1, 34};
        vecs[4]  = '{3'd1, 32'd7,         32'd0,        32'd7,        32'hFFFFFFFF, 32'd7,        32'd0, 34};
        vecs[5]  = '{3'd2, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0,        32'd0, 0};
        vecs[6]  = '{3'd3, 32'hFFFFFFFF,  32'd2,        32'd1,        32'hFFFFFFFE, 32'd0,        32'd0, 0};
        vecs[7]  = '{3'd4, 32'h1234,      32'd9,        32'h1234,     32'hFFFFFFFE, 32'd0,        32'd0, 0};
        vecs[8]  = '{3'd5, 32'hABCD,      32'd9,        32'h1234,     32'hABCD,     32'd0,        32'd0, 0};
        vecs[9]  = '{3'd6, 32'd5,         32'd5,        32'h1234,     32'hABCD,     32'd0,        32'd0, 0};
        vecs[10] = '{3'd0, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       32'd100,      32'd7, 34};
        vecs[11] = '{3'd0, 32'hFFFFFFFB,  32'd0,        32'hFFFFFFFB, 32'd1,        32'd5,        32'd0, 34};

        reset    = 1'b0;
        flush    = 1'b0;
        op_valid = 1'b0;
        op       = 3'd0;
        rs_data  = '0;
        rt_data  = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_div_en", {31'd0, div_en}, 32'd0);
        check("rst_dvd", div_dividend, '0);
        check("rst_dvs", div_divisor, '0);
        reset = 1'b1;
        @(negedge clk);

        // Table: each op issued in the first idle cycle after the previous one.
        for (int i = 0; i < 12; i++) begin
            apply_op(vecs[i].op, vecs[i].rs, vecs[i].rt);
            if (vecs[i].exp_busy != 0) begin
                check($sformatf("v%0d_div_en_run", i), {31'd0, div_en}, 32'd1);
                check($sformatf("v%0d_dvd", i), div_dividend, vecs[i].exp_dvd);
                check($sformatf("v%0d_dvs", i), div_divisor, vecs[i].exp_dvs);
            end
            count_busy(n);
            check($sformatf("v%0d_busy_cycles", i), n, vecs[i].exp_busy);
            check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            check($sformatf("v%0d_div_en_after", i), {31'd0, div_en}, 32'd0);
        end

        // Flush on cycle 10 of a divide; an op presented during RUN is ignored.
        apply_op(3'd1, 32'd100, 32'd7);
        op_valid = 1'b1;
        op       = 3'd4;
        rs_data  = 32'hDEAD;
        repeat (9) @(negedge clk);
        op_valid = 1'b0;
        check("flush_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_div_en", {31'd0, div_en}, 32'd0);
        check("flush_hi", hi, 32'hFFFFFFFB);
        check("flush_lo", lo, 32'd1);
        apply_op(3'd1, 32'd9, 32'd4);
        count_busy(n);
        check("after_flush_busy_cycles", n, 34);
        check("after_flush_lo", lo, 32'd2);
        check("after_flush_hi", hi, 32'd1);

        // Flush with an op in IDLE discards the op.
        flush = 1'b1;
        apply_op(3'd5, 32'h55, 32'd0);
        flush = 1'b0;
        check("flush_idle_lo", lo, 32'd2);
        check("flush_idle_busy", {31'd0, busy}, 32'd0);

        // Flush on the completion cycle: result dropped.
        apply_op(3'd1, 32'd100, 32'd7);
        n = 0;
        while (!div_complete && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("complete_seen", {31'd0, div_complete}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_cmpl_hi", hi, 32'd1);
        check("flush_cmpl_lo", lo, 32'd2);
        check("flush_cmpl_busy", {31'd0, busy}, 32'd0);

        // Reset on cycle 20 of a divide.
        apply_op(3'd0, 32'hFFFFFF9C, 32'd7);
        repeat (19) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_hi", hi, '0);
        check("mid_rst_lo", lo, '0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_div_en", {31'd0, div_en}, 32'd0);
        check("mid_rst_dvd", div_dividend, '0);
        reset = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- HI/LO register unit for the execute stage. It owns architectural HI/LO and sequences DIV/DIVU through the iterative unsigned restoring divider.
- Converts signed operands to magnitudes, drives the divider, and consumes its quotient/remainder.
- Applies MIPS sign correction and writes HI (remainder) and LO (quotient).
- Handles MULT/MULTU/MTHI/MTLO directly. Raises busy so the pipeline stalls HI/LO consumers.

Parameters:
WIDTH, 32, operand/HI/LO width; divider instantiated with same WIDTH.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
flush  input  1  synchronous cancel (exception/branch flush), active-high
op_valid  input  1  op presented this cycle
op  input  3  0=DIV 1=DIVU 2=MULT 3=MULTU 4=MTHI 5=MTLO, 6/7 reserved (no-op)
rs_data  input  WIDTH  dividend / multiplicand / MTHI-MTLO source
rt_data  input  WIDTH  divisor / multiplier
busy  output  1  divide in flight; HI/LO not valid, no op accepted
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
div_en  output  1  divider enable; low resets divider sequence
div_dividend  output  WIDTH  unsigned dividend magnitude to divider
div_divisor  output  WIDTH  unsigned divisor magnitude to divider
div_quotient  input  WIDTH  divider quotient
div_remainder  input  WIDTH  divider remainder
div_complete  input  1  divider result valid

Behaviour:
- Reset (reset==0 at posedge):
  - State=IDLE; hi=0, lo=0.
  - div_dividend=0, div_divisor=0; q_neg=r_neg=0.
  - Outputs: div_en=0, busy=0.
  - Applies mid-divide too.
- States: IDLE, RUN. busy = (state==RUN); div_en = (state==RUN), decoded from the state register only.
- IDLE, op_valid, no flush, at posedge:
  - DIV:
    - div_dividend <= |rs|, div_divisor <= |rt|. Magnitudes use two's-complement negate; |0x80000000| = 0x80000000 unsigned.
    - q_neg <= rs[W-1]^rt[W-1]; r_neg <= rs[W-1].
    - Next state RUN.
  - DIVU: operands raw, q_neg=r_neg=0, next state RUN.
  - MULT: {hi,lo} <= signed 2W-bit product. MULTU: unsigned product. One cycle, busy stays 0.
  - MTHI: hi <= rs_data. MTLO: lo <= rs_data.
  - Reserved op: no effect.
- RUN:
  - div_dividend/div_divisor held stable; op_valid ignored. The pipeline must hold the op.
  - On posedge with div_complete=1:
    - lo <= q_neg ? -div_quotient : div_quotient.
    - hi <= r_neg ? -div_remainder : div_remainder.
    - Next state IDLE, so div_en falls and the divider reinitialises.
- Latency, WIDTH=32:
  - Accept at edge E0; div_en high from E0.
  - div_complete seen after E33; captured at E34.
  - busy high exactly 34 cycles. hi/lo readable in the cycle after E34.
  - General: WIDTH+2 cycles.
- Back-to-back divides:
  - A new DIV can be accepted in the first IDLE cycle after completion.
  - div_en is low during that cycle, which guarantees divider restart.
- Divide by zero:
  - No trap; the full sequence runs.
  - Result is the divider output with sign correction. For DIVU x/0: lo=all-ones, hi=x.
- Signed overflow: 0x80000000 / -1 gives lo=0x80000000, hi=0 (q_neg=0).
- flush:
  - In RUN: next state IDLE, div_en low, hi/lo unchanged.
  - flush and div_complete in the same cycle: flush wins, hi/lo unchanged.
  - flush with op_valid in IDLE: op discarded.
- reset has priority over flush and all ops.
- hi/lo are pure registers. They change only at the edges listed above.

Test Plan:
1. DIVU rs=100, rt=7 -> busy high 34 cycles; then lo=14, hi=2; div_en=0 the cycle after completion.
2. DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV rs=7, rt=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
3. DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=7.
4. MULT rs=0xFFFFFFFF, rt=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, busy never high. MULTU same operands -> hi=1, lo=0xFFFFFFFE. Then MTHI 0x1234 -> hi=0x1234, lo unchanged.
5. DIVU 100/7, then flush on cycle 10 of RUN -> busy=0 and div_en=0 next cycle, hi/lo keep prior values. Immediately issue DIVU 9/4 -> lo=2, hi=1 after 34 cycles.
6. DIV in flight, reset=0 on cycle 20 -> hi=lo=0, busy=0. Also assert flush on the div_complete cycle -> hi/lo unchanged.
